// File: rtl/pa_horner_hash_pkg.sv
// Shared constants and state encoding for the Horner polynomial hash engine.
// Q = 2^24-3 and MU = floor(2^50/Q) drive the Barrett reduction.
package pa_pkg;
  localparam int W        = 24;
  localparam int DW       = 2 * W;
  localparam int SW       = 2 * W + 1;
  localparam int MU_W     = 27;
  localparam int MU_SHIFT = 50;

  localparam logic [W-1:0]    Q  = 24'd16777213;
  localparam logic [MU_W-1:0] MU = MU_W'((64'd1 << MU_SHIFT) / 64'(Q));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    MUL    = 3'd2,
    ADD    = 3'd3,
    RED    = 3'd4,
    OUT    = 3'd5
  } state_t;
endpackage

// File: rtl/pa_mod_reduce.sv
// Registered Barrett reduction of a 49-bit sum modulo Q. The output register is
// the hash accumulator itself: loaded on i_en, cleared to 0 on i_clr.
module pa_mod_reduce
  import pa_pkg::*;
(
  input  logic          clk_100Mhz,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [SW-1:0] i_sum,
  output logic [W-1:0]  o_res
);
  localparam int BW = SW + MU_W;
  localparam int QW = BW - MU_SHIFT;
  localparam int RW = W + 2;

  logic [BW-1:0] w_prod;
  logic [QW-1:0] w_qhat;
  logic [RW-1:0] w_qq;
  logic [RW-1:0] w_r0;
  logic [RW-1:0] w_r1;
  logic [RW-1:0] w_r2;
  logic          w_unused;
  logic [W-1:0]  r_res;

  // qhat underestimates floor(s/Q) by at most 1, so the remainder is < 3Q and
  // fits in W+2 bits; computing it modulo 2^(W+2) is therefore exact.
  assign w_prod = BW'(i_sum) * BW'(MU);
  assign w_qhat = w_prod[BW-1:MU_SHIFT];
  assign w_qq   = RW'(w_qhat) * RW'(Q);
  assign w_r0   = i_sum[RW-1:0] - w_qq;
  assign w_r1   = (w_r0 >= RW'(Q)) ? (w_r0 - RW'(Q)) : w_r0;
  assign w_r2   = (w_r1 >= RW'(Q)) ? (w_r1 - RW'(Q)) : w_r1;

  assign w_unused = ^{w_prod[MU_SHIFT-1:0], w_r2[RW-1:W]};

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (i_clr) begin
      r_res <= '0;
    end else if (i_en) begin
      r_res <= w_r2[W-1:0];
    end
  end

  assign o_res = r_res;
endmodule

// File: rtl/pa_horner_hash.sv
// Horner polynomial hash controller: H = (((k0*r + k1)*r + k2)...) mod Q, one word per 4 cycles.
// Optional PA_WORD_CNT_EN adds o_word_cnt, the saturating count of words absorbed.
module pa_horner_hash
  import pa_pkg::*;
(
  input  logic         clk_100Mhz,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_seed,
  input  logic [W-1:0] i_word,
  input  logic         i_word_valid,
  input  logic         i_word_last,
  output logic         o_word_ready,
  output logic [W-1:0] o_hash,
  output logic         o_hash_valid,
  input  logic         i_hash_ready,
`ifdef PA_WORD_CNT_EN
  output logic [15:0]  o_word_cnt,
`endif
  output logic         o_busy
);
  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_seed;
  logic [W-1:0]  r_word;
  logic          r_last;
  logic [DW-1:0] r_prod;
  logic [SW-1:0] r_sum;
  logic [W-1:0]  w_acc;
  logic          w_start_acc;
  logic          w_word_hs;

  assign w_start_acc = (r_state == IDLE) && i_start;
  assign w_word_hs   = (r_state == ACCEPT) && i_word_valid;

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = ACCEPT;
      ACCEPT:  if (i_word_valid) w_next = MUL;
      MUL:     w_next = ADD;
      ADD:     w_next = RED;
      RED:     w_next = r_last ? OUT : ACCEPT;
      OUT:     if (i_hash_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_seed <= '0;
      r_word <= '0;
      r_last <= 1'b0;
      r_prod <= '0;
      r_sum  <= '0;
    end else begin
      if (w_start_acc) begin
        r_seed <= i_seed;
      end
      if (w_word_hs) begin
        r_word <= i_word;
        r_last <= i_word_last;
      end
      if (r_state == MUL) begin
        r_prod <= DW'(w_acc) * DW'(r_seed);
      end
      if (r_state == ADD) begin
        r_sum <= SW'(r_prod) + SW'(r_word);
      end
    end
  end

  pa_mod_reduce u_reduce (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .i_en       (r_state == RED),
    .i_clr      (w_start_acc),
    .i_sum      (r_sum),
    .o_res      (w_acc)
  );

`ifdef PA_WORD_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_start_acc) begin
      r_word_cnt <= '0;
    end else if (w_word_hs && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign o_word_cnt = r_word_cnt;
`endif

  // acc only changes in RED or on an accepted start, so it is stable throughout OUT.
  assign o_hash       = w_acc;
  assign o_word_ready = (r_state == ACCEPT);
  assign o_hash_valid = (r_state == OUT);
  assign o_busy       = (r_state != IDLE);
endmodule

// File: tb/tb_pa_horner_hash.sv
// Self-checking bench for pa_horner_hash: directed cases plus random messages
// against a plain modular-arithmetic reference of the Horner hash.
module tb_pa_horner_hash;
  import pa_pkg::*;

  logic         clk_100Mhz = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_seed;
  logic [W-1:0] i_word;
  logic         i_word_valid;
  logic         i_word_last;
  logic         o_word_ready;
  logic [W-1:0] o_hash;
  logic         o_hash_valid;
  logic         i_hash_ready;
  logic         o_busy;
`ifdef PA_WORD_CNT_EN
  logic [15:0]  o_word_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;

  pa_horner_hash dut (
    .clk_100Mhz   (clk_100Mhz),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_seed       (i_seed),
    .i_word       (i_word),
    .i_word_valid (i_word_valid),
    .i_word_last  (i_word_last),
    .o_word_ready (o_word_ready),
    .o_hash       (o_hash),
    .o_hash_valid (o_hash_valid),
    .i_hash_ready (i_hash_ready),
`ifdef PA_WORD_CNT_EN
    .o_word_cnt   (o_word_cnt),
`endif
    .o_busy       (o_busy)
  );

  function automatic logic [W-1:0] ref_hash(input logic [W-1:0] seed, input logic [W-1:0] msg[$]);
    longint unsigned acc;
    acc = 0;
    foreach (msg[i]) acc = (acc * longint'(seed) + longint'(msg[i])) % longint'(Q);
    return W'(acc);
  endfunction

  task automatic do_start(input logic [W-1:0] seed);
    i_start = 1'b1;
    i_seed  = seed;
    @(negedge clk_100Mhz);
    i_start = 1'b0;
    i_seed  = W'($urandom);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk_100Mhz);
    i_word_valid = 1'b1;
    i_word       = w;
    i_word_last  = last;
    n = 0;
    while (!o_word_ready && n < 40) begin
      @(negedge clk_100Mhz);
      n++;
    end
    checks++;
    if (o_word_ready !== 1'b1) begin
      errors++;
      $display("FAIL word_handshake: o_word_ready=%0b after %0d cycles, required 1", o_word_ready, n);
    end
    @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
    i_word       = W'($urandom);
  endtask

  task automatic send_msg(input logic [W-1:0] seed, input logic [W-1:0] msg[$], input int max_gap);
    do_start(seed);
    foreach (msg[i]) send_word(msg[i], (i == msg.size() - 1), $urandom_range(0, max_gap));
  endtask

  task automatic wait_hash(output int n);
    n = 0;
    while (!o_hash_valid && n < 60) begin
      @(negedge clk_100Mhz);
      n++;
    end
  endtask

  task automatic take_hash();
    i_hash_ready = 1'b1;
    @(negedge clk_100Mhz);
    i_hash_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100Mhz);
    checks++;
    if ({o_hash, o_hash_valid, o_word_ready, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hash=%0d valid=%0b ready=%0b busy=%0b, required all 0",
               o_hash, o_hash_valid, o_word_ready, o_busy);
    end
`ifdef PA_WORD_CNT_EN
    checks++;
    if (o_word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_word_cnt: got %0d, required 0", o_word_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk_100Mhz);
  endtask

  task automatic test_basic(input string tag);
    logic [W-1:0] msg[$];
    int n;
    msg = '{24'd1, 24'd2, 24'd3};
    send_msg(24'd2, msg, 0);
    wait_hash(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL %s_latency: valid after %0d cycles, required 3", tag, n);
    end
    checks++;
    if (o_hash !== 24'd11) begin
      errors++;
      $display("FAIL %s_hash: got %0d, required 11", tag, o_hash);
    end
`ifdef PA_WORD_CNT_EN
    checks++;
    if (o_word_cnt !== 16'd3) begin
      errors++;
      $display("FAIL %s_word_cnt: got %0d, required 3", tag, o_word_cnt);
    end
`endif
    take_hash();
    checks++;
    if (o_busy !== 1'b0 || o_hash_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after_take: busy=%0b valid=%0b, required 0 0", tag, o_busy, o_hash_valid);
    end
  endtask

  task automatic test_directed(input string tag, input logic [W-1:0] seed,
                               input logic [W-1:0] msg[$], input logic [W-1:0] exp);
    int n;
    send_msg(seed, msg, 1);
    wait_hash(n);
    checks++;
    if (o_hash_valid !== 1'b1 || o_hash !== exp) begin
      errors++;
      $display("FAIL %s: valid=%0b hash=%0d, required valid=1 hash=%0d", tag, o_hash_valid, o_hash, exp);
    end
    take_hash();
  endtask

  task automatic test_hold();
    logic [W-1:0] msg[$];
    logic [W-1:0] seed;
    logic [W-1:0] exp;
    int n;
    seed = W'($urandom);
    msg = '{W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
    exp = ref_hash(seed, msg);
    send_msg(seed, msg, 0);
    wait_hash(n);
    for (int c = 0; c < 10; c++) begin
      i_start      = 1'($urandom_range(0, 1));
      i_word_valid = 1'($urandom_range(0, 1));
      i_seed       = W'($urandom);
      @(negedge clk_100Mhz);
      checks++;
      if (o_hash_valid !== 1'b1 || o_hash !== exp || o_word_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%0b hash=%0d ready=%0b, required 1 %0d 0",
                 c, o_hash_valid, o_hash, o_word_ready, exp);
      end
    end
    i_word_valid = 1'b0;
    i_start      = 1'b1;
    i_hash_ready = 1'b1;
    @(negedge clk_100Mhz);
    i_start      = 1'b0;
    i_hash_ready = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_hash_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_take_with_start: busy=%0b valid=%0b, required 0 0", o_busy, o_hash_valid);
    end
    @(negedge clk_100Mhz);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored: busy=%0b, required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_start(24'd2);
    send_word(24'd1, 1'b0, 0);
    send_word(24'd2, 1'b0, 0);
    @(negedge clk_100Mhz);
    checks++;
    if (o_busy !== 1'b1 || o_hash !== 24'd1) begin
      errors++;
      $display("FAIL reset_mid_pre: busy=%0b hash=%0d, required 1 1", o_busy, o_hash);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_hash, o_hash_valid, o_word_ready, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: hash=%0d valid=%0b ready=%0b busy=%0b, required all 0",
               o_hash, o_hash_valid, o_word_ready, o_busy);
    end
    @(negedge clk_100Mhz);
    rst_n = 1'b1;
    @(negedge clk_100Mhz);
    test_basic("reset_mid_restart");
  endtask

  task automatic test_random();
    logic [W-1:0] msg[$];
    logic [W-1:0] seed;
    logic [W-1:0] exp;
    int len;
    int n;
    for (int t = 0; t < 25; t++) begin
      msg.delete();
      seed = (t == 0) ? 24'd0 : ((t == 1) ? 24'hFFFFFF : W'($urandom));
      len  = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) msg.push_back(W'(Q + W'($urandom_range(0, 2))));
        else msg.push_back(W'($urandom));
      end
      exp = ref_hash(seed, msg);
      send_msg(seed, msg, 3);
      wait_hash(n);
      checks++;
      if (o_hash_valid !== 1'b1 || o_hash !== exp) begin
        errors++;
        $display("FAIL random%0d_hash: valid=%0b hash=%0d, required valid=1 hash=%0d (len %0d)",
                 t, o_hash_valid, o_hash, exp, len);
      end
`ifdef PA_WORD_CNT_EN
      checks++;
      if (o_word_cnt !== 16'(len)) begin
        errors++;
        $display("FAIL random%0d_word_cnt: got %0d, required %0d", t, o_word_cnt, len);
      end
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk_100Mhz);
      take_hash();
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_seed       = '0;
    i_word       = '0;
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
    i_hash_ready = 1'b0;
    @(negedge clk_100Mhz);
    test_reset();
    test_basic("basic");
    test_directed("wrap_max", W'(Q - 24'd1), '{W'(Q - 24'd1), W'(Q - 24'd1)}, 24'd0);
    test_directed("fold_word", 24'd5, '{24'hFFFFFF}, 24'd2);
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
